// File: rtl/sad_min_search.sv
// Block-matching minimum search: streams BLK*BLK pixel pairs per candidate,
// accumulates SAD or SSD through a 3-stage pipeline and reports the cheapest candidate.
module sad_min_search #(
    parameter int  PIX_W = 8,
    parameter int  BLK   = 4,
    parameter int  NCAND = 16,
    localparam int NPIX  = BLK * BLK,
    localparam int ACC_W = 2 * PIX_W + $clog2(NPIX),
    localparam int IDX_W = ($clog2(NCAND) > 1) ? $clog2(NCAND) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_in_valid,
    input  logic [PIX_W-1:0] i_in_cur,
    input  logic [PIX_W-1:0] i_in_ref,
    output logic             o_in_ready,
    output logic             o_busy,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [ACC_W-1:0] o_res_cost,
    output logic [IDX_W-1:0] o_res_idx
);

    localparam int PC_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_mode;
    logic [PC_W-1:0]    r_pix_cnt;
    logic [IDX_W-1:0]   r_cand_cnt;
    logic [IDX_W-1:0]   r_cmp_idx;
    logic [ACC_W-1:0]   r_best;
    logic [IDX_W-1:0]   r_best_idx;
    logic               r_fin;
    logic [ACC_W-1:0]   r_res_cost;
    logic [IDX_W-1:0]   r_res_idx;

    // pipeline: r_vld[0] = stage 1 holds a pair, [1] = stage 2, [2] = stage 3
    logic [2:0]         r_vld;
    logic [PIX_W:0]     r_s1_diff;
    logic               r_s1_first, r_s1_last;
    logic [ACC_W-1:0]   r_s2_mag;
    logic               r_s2_first, r_s2_last;
    logic [ACC_W-1:0]   r_acc;
    logic               r_s3_last;

    logic               w_accept, w_start_go, w_pix_last, w_cand_last;
    logic [PIX_W:0]     w_diff;
    logic [PIX_W-1:0]   w_lo, w_abs;
    logic [2*PIX_W-1:0] w_sq;
    logic [ACC_W-1:0]   w_mag;

    assign w_accept    = i_in_valid && (r_state == S_RUN);
    assign w_start_go  = i_start && (r_state == S_IDLE);
    assign w_pix_last  = (r_pix_cnt == PC_W'(NPIX - 1));
    assign w_cand_last = (r_cand_cnt == IDX_W'(NCAND - 1));

    assign w_diff = {1'b0, i_in_cur} - {1'b0, i_in_ref};
    // two's-complement negate of the low bits gives |diff| since |diff| < 2**PIX_W
    assign w_lo   = r_s1_diff[PIX_W-1:0];
    assign w_abs  = r_s1_diff[PIX_W] ? ((~w_lo) + PIX_W'(1)) : w_lo;
    assign w_sq   = {{PIX_W{1'b0}}, w_abs} * {{PIX_W{1'b0}}, w_abs};
    assign w_mag  = r_mode ? ACC_W'(w_sq) : ACC_W'(w_abs);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && w_pix_last && w_cand_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_fin) w_state_nxt = S_DONE;
            S_DONE:  if (i_res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld      <= '0;
            r_s1_diff  <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_acc      <= '0;
            r_s3_last  <= 1'b0;
        end else begin
            r_vld      <= {r_vld[1:0], w_accept};
            r_s1_first <= (r_pix_cnt == '0);
            r_s1_last  <= w_accept && w_pix_last;
            if (w_accept) r_s1_diff <= w_diff;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_vld[0] && r_s1_last;
            if (r_vld[0]) r_s2_mag <= w_mag;
            r_s3_last  <= r_vld[1] && r_s2_last;
            if (r_vld[1]) r_acc <= r_s2_first ? r_s2_mag : (r_acc + r_s2_mag);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= 1'b0;
            r_pix_cnt  <= '0;
            r_cand_cnt <= '0;
            r_cmp_idx  <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_fin      <= 1'b0;
        end else if (w_start_go) begin
            r_mode     <= i_mode;
            r_pix_cnt  <= '0;
            r_cand_cnt <= '0;
            r_cmp_idx  <= '0;
            r_best     <= '1;
            r_best_idx <= '0;
            r_fin      <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_pix_last) begin
                    r_pix_cnt  <= '0;
                    r_cand_cnt <= r_cand_cnt + IDX_W'(1);
                end else begin
                    r_pix_cnt  <= r_pix_cnt + PC_W'(1);
                end
            end
            // candidate cost leaves stage 3: strict compare keeps the lowest index on ties
            if (r_vld[2] && r_s3_last) begin
                if (r_acc < r_best) begin
                    r_best     <= r_acc;
                    r_best_idx <= r_cmp_idx;
                end
                r_cmp_idx <= r_cmp_idx + IDX_W'(1);
                if (r_cmp_idx == IDX_W'(NCAND - 1)) r_fin <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_cost <= '0;
            r_res_idx  <= '0;
        end else if (r_state == S_DRAIN && r_fin) begin
            r_res_cost <= r_best;
            r_res_idx  <= r_best_idx;
        end
    end

    assign o_in_ready  = (r_state == S_RUN);
    assign o_busy      = (r_state != S_IDLE);
    assign o_res_valid = (r_state == S_DONE);
    assign o_res_cost  = r_res_cost;
    assign o_res_idx   = r_res_idx;

endmodule

// File: tb/tb_sad_min_search.sv
// Directed/random bench for sad_min_search: a default-parameter instance checked
// against a per-candidate cost model, plus a small BLK=2/NCAND=4 instance.
module tb_sad_min_search;

    localparam int NC = 16;
    localparam int NP = 256;
    localparam int AW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_start, a_mode, a_iv, a_ir, a_busy, a_rv, a_rr;
    logic [7:0]    a_cur, a_ref;
    logic [AW-1:0] a_cost;
    logic [3:0]    a_idx;

    logic          b_start, b_mode, b_iv, b_ir, b_busy, b_rv, b_rr;
    logic [7:0]    b_cur, b_ref;
    logic [17:0]   b_cost;
    logic [1:0]    b_idx;

    sad_min_search dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_mode(a_mode),
        .i_in_valid(a_iv), .i_in_cur(a_cur), .i_in_ref(a_ref), .o_in_ready(a_ir),
        .o_busy(a_busy), .o_res_valid(a_rv), .i_res_ready(a_rr),
        .o_res_cost(a_cost), .o_res_idx(a_idx)
    );

    sad_min_search #(.PIX_W(8), .BLK(2), .NCAND(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_mode(b_mode),
        .i_in_valid(b_iv), .i_in_cur(b_cur), .i_in_ref(b_ref), .o_in_ready(b_ir),
        .o_busy(b_busy), .o_res_valid(b_rv), .i_res_ready(b_rr),
        .o_res_cost(b_cost), .o_res_idx(b_idx)
    );

    int n_pass = 0;
    int n_tot  = 0;
    logic [7:0] m_cur [NP];
    logic [7:0] m_ref [NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // per-candidate cost from arithmetic on the pair arrays; strict min, lowest index wins
    function automatic void model(input bit m, output int cost, output int idx);
        int best, s, d;
        best = 32'h7fffffff;
        idx  = 0;
        for (int k = 0; k < NC; k++) begin
            s = 0;
            for (int j = 0; j < NP / NC; j++) begin
                d = int'(m_cur[k*(NP/NC)+j]) - int'(m_ref[k*(NP/NC)+j]);
                s += m ? d * d : (d < 0 ? -d : d);
            end
            if (s < best) begin
                best = s;
                idx  = k;
            end
        end
        cost = best;
    endfunction

    task automatic fill_rand(input int maxv);
        for (int i = 0; i < NP; i++) begin
            m_cur[i] = 8'($urandom_range(maxv));
            m_ref[i] = 8'($urandom_range(maxv));
        end
    endtask

    // called at a negedge; abort_at >= 0 pulls reset low when that pair index is reached
    task automatic run_a(input bit m, input int bub, input int stall, input bit poke,
                         input int abort_at, input string tag,
                         output logic [AW-1:0] cost, output logic [3:0] idx);
        int p, guard, n, ec, ei;
        bit acc;
        model(m, ec, ei);
        cost = '0;
        idx  = '0;
        a_start = 1'b1;
        a_mode  = m;
        @(negedge clk);
        a_start = 1'b0;
        chk({tag, "_busy_run"}, 64'(a_busy), 64'(1));
        chk({tag, "_ready_run"}, 64'(a_ir), 64'(1));
        p = 0;
        guard = 0;
        while (p < NP && guard < 4000) begin
            if (p == abort_at) begin
                rst_n = 1'b0;
                a_iv  = 1'b0;
                a_start = 1'b0;
                #1;
                chk({tag, "_rst_ready"}, 64'(a_ir), 64'(0));
                chk({tag, "_rst_busy"}, 64'(a_busy), 64'(0));
                chk({tag, "_rst_valid"}, 64'(a_rv), 64'(0));
                chk({tag, "_rst_cost"}, 64'(a_cost), 64'(0));
                chk({tag, "_rst_idx"}, 64'(a_idx), 64'(0));
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            a_iv    = ($urandom_range(99) >= bub);
            a_cur   = a_iv ? m_cur[p] : 8'($urandom);
            a_ref   = a_iv ? m_ref[p] : 8'($urandom);
            a_start = poke && ($urandom_range(15) == 0);
            acc     = a_iv && a_ir;
            @(negedge clk);
            if (acc) p++;
            guard++;
        end
        a_iv    = 1'b0;
        a_start = 1'b0;
        chk({tag, "_pairs_fed"}, 64'(p), 64'(NP));
        chk({tag, "_ready_drain"}, 64'(a_ir), 64'(0));
        n = 0;
        while (!a_rv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(4));
        chk({tag, "_cost"}, 64'(a_cost), 64'(ec));
        chk({tag, "_idx"}, 64'(a_idx), 64'(ei));
        cost = a_cost;
        idx  = a_idx;
        for (int s = 0; s < stall; s++) begin
            a_rr    = 1'b0;
            a_start = poke;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(a_rv), 64'(1));
            chk({tag, "_hold_cost"}, 64'(a_cost), 64'(cost));
            chk({tag, "_hold_idx"}, 64'(a_idx), 64'(idx));
            chk({tag, "_hold_busy"}, 64'(a_busy), 64'(1));
        end
        a_rr    = 1'b1;
        a_start = poke;
        @(negedge clk);
        a_rr    = 1'b0;
        a_start = 1'b0;
        chk({tag, "_valid_fall"}, 64'(a_rv), 64'(0));
        chk({tag, "_idle_busy"}, 64'(a_busy), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc [16] = '{110,110,110,110, 20,20,20,20, 0,5,5,5, 200,1,1,1};
        int br [16] = '{100,100,100,100, 23,23,23,23, 12,5,5,5, 170,1,1,1};
        logic [AW-1:0] c1, c2;
        logic [3:0]    i1, i2;
        int n;

        rst_n = 1'b0;
        a_start = 0; a_mode = 0; a_iv = 0; a_cur = 0; a_ref = 0; a_rr = 0;
        b_start = 0; b_mode = 0; b_iv = 0; b_cur = 0; b_ref = 0; b_rr = 0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(a_ir), 64'(0));
        chk("reset_busy", 64'(a_busy), 64'(0));
        chk("reset_valid", 64'(a_rv), 64'(0));
        chk("reset_cost", 64'(a_cost), 64'(0));
        chk("reset_idx", 64'(a_idx), 64'(0));
        rst_n = 1'b1;

        // small instance: costs 40, 12, 12, 30 -> tie resolved to index 1
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int p = 0; p < 16; p++) begin
            b_iv  = 1'b1;
            b_cur = 8'(bc[p]);
            b_ref = 8'(br[p]);
            @(negedge clk);
        end
        b_iv = 1'b0;
        n = 0;
        while (!b_rv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("small_latency", 64'(n), 64'(4));
        chk("small_cost", 64'(b_cost), 64'(12));
        chk("small_idx", 64'(b_idx), 64'(1));
        b_rr = 1'b1;
        @(negedge clk);
        b_rr = 1'b0;
        chk("small_valid_fall", 64'(b_rv), 64'(0));

        // single max difference in candidate 0, everything else equal
        for (int i = 0; i < NP; i++) begin
            m_cur[i] = 8'($urandom);
            m_ref[i] = m_cur[i];
        end
        m_cur[0] = 8'd255;
        m_ref[0] = 8'd0;
        run_a(1'b1, 0, 0, 1'b0, -1, "ssd_one", c1, i1);
        chk("ssd_one_cost_const", 64'(c1), 64'(0));
        chk("ssd_one_idx_const", 64'(i1), 64'(1));

        for (int i = 0; i < NP; i++) begin
            m_cur[i] = 8'd255;
            m_ref[i] = 8'd0;
        end
        run_a(1'b1, 0, 0, 1'b0, -1, "ssd_max", c1, i1);
        chk("ssd_max_cost_const", 64'(c1), 64'(1040400));
        chk("ssd_max_idx_const", 64'(i1), 64'(0));

        // same data gap-free and with 50% bubbles must give identical results
        fill_rand(15);
        run_a(1'b0, 0, 0, 1'b0, -1, "sad_nogap", c1, i1);
        run_a(1'b0, 50, 3, 1'b0, -1, "sad_bub", c2, i2);
        chk("bub_same_cost", 64'(c2), 64'(c1));
        chk("bub_same_idx", 64'(i2), 64'(i1));

        fill_rand(255);
        run_a(1'b1, 50, 3, 1'b0, -1, "ssd_bub", c1, i1);

        // start pulses in RUN, DONE and at the handshake are ignored
        fill_rand(31);
        run_a(1'b0, 30, 2, 1'b1, -1, "poke", c1, i1);

        // reset in candidate 2, then a search launched on the first edge after release
        fill_rand(255);
        run_a(1'b1, 20, 0, 1'b0, 2*16+5, "abort", c1, i1);
        fill_rand(63);
        run_a(1'b0, 0, 1, 1'b0, -1, "fresh", c1, i1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
